// File: rtl/logic_unit_sequencer.sv
// logic_unit_sequencer: command-side front end for the 32-bit logic unit.
// Accepts one op at a time, drives f1/f0/a/b to the logic unit, holds them
// for SETTLE cycles, captures the result and returns it on a response channel.
module logic_unit_sequencer #(
  parameter int WIDTH  = 32,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic             lu_f1,
  output logic             lu_f0,
  output logic [WIDTH-1:0] lu_a,
  output logic [WIDTH-1:0] lu_b,
  input  logic [WIDTH-1:0] lu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_ISSUE = 2'b01;
  localparam logic [1:0] ST_RESP  = 2'b10;

  // Last settle-count value; the result is captured on the edge that sees it.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0] state_r;
  logic [3:0] settle_cnt_r;

  // Request channel is open only while nothing is in flight.
  assign cmd_ready = (state_r == ST_IDLE);

  // Sequencer state, settle counter and logic-unit drives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      settle_cnt_r <= 4'd0;
      lu_f1        <= 1'b0;
      lu_f0        <= 1'b0;
      lu_a         <= {WIDTH{1'b0}};
      lu_b         <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid) begin
            // An illegal op (00) loads 00 into f1/f0, so the unit stays idle.
            lu_f1        <= cmd_op[1];
            lu_f0        <= cmd_op[0];
            lu_a         <= cmd_a;
            lu_b         <= cmd_b;
            settle_cnt_r <= 4'd0;
            state_r      <= (cmd_op == 2'b00) ? ST_RESP : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (settle_cnt_r == SETTLE_LAST) begin
            // Result captured this edge; park the unit, keep operands as-is.
            lu_f1        <= 1'b0;
            lu_f0        <= 1'b0;
            settle_cnt_r <= 4'd0;
            state_r      <= ST_RESP;
          end else begin
            settle_cnt_r <= settle_cnt_r + 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          lu_f1        <= 1'b0;
          lu_f0        <= 1'b0;
          settle_cnt_r <= 4'd0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

  // Response channel: capture result or error, hold until consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= {WIDTH{1'b0}};
      rsp_err   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid && (cmd_op == 2'b00)) begin
            rsp_valid <= 1'b1;
            rsp_data  <= {WIDTH{1'b0}};
            rsp_err   <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (settle_cnt_r == SETTLE_LAST) begin
            rsp_valid <= 1'b1;
            rsp_data  <= lu_out;
            rsp_err   <= 1'b0;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  // Completed-operation counter: successful responses only, wraps naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_count <= {CNT_W{1'b0}};
    end else if ((state_r == ST_RESP) && rsp_ready && !rsp_err) begin
      op_count <= op_count + CNT_ONE;
    end else begin
      op_count <= op_count;
    end
  end

endmodule

// File: tb/tb_logic_unit_sequencer.sv
// Bench for logic_unit_sequencer: one SETTLE=1 instance and one SETTLE=3
// instance with a 4-bit counter (to reach the wrap point quickly).
module tb_logic_unit_sequencer;

  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // SETTLE=1 instance signals
  logic         cmd_valid, cmd_ready, lu_f1, lu_f0, rsp_valid, rsp_ready, rsp_err;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_a, cmd_b, lu_a, lu_b, lu_out, rsp_data;
  logic [15:0]  op_count;

  // SETTLE=3 instance signals
  logic         c3_cmd_valid, c3_cmd_ready, c3_lu_f1, c3_lu_f0, c3_rsp_valid, c3_rsp_ready, c3_rsp_err;
  logic [1:0]   c3_cmd_op;
  logic [W-1:0] c3_cmd_a, c3_cmd_b, c3_lu_a, c3_lu_b, c3_lu_out, c3_rsp_data;
  logic [3:0]   c3_op_count;

  int total = 0;
  int bad   = 0;

  logic [W:0] q1[$];
  logic [W:0] q3[$];

  logic watch_f = 1'b0;
  logic f_seen  = 1'b0;

  localparam logic [W-1:0] A0 = 32'hDC754CD2;
  localparam logic [W-1:0] B0 = 32'h4124F055;

  // Behavioural logic unit: select 00 forces zero.
  function automatic logic [W-1:0] lu_fn(input logic f1, input logic f0,
                                         input logic [W-1:0] a, input logic [W-1:0] b);
    case ({f1, f0})
      2'b01:   return a & b;
      2'b10:   return a | b;
      2'b11:   return a ^ b;
      default: return {W{1'b0}};
    endcase
  endfunction

  // Expected response {err, data} for a request.
  function automatic logic [W:0] rsp_model(input logic [1:0] op,
                                           input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      2'b01:   return {1'b0, a & b};
      2'b10:   return {1'b0, a | b};
      2'b11:   return {1'b0, a ^ b};
      default: return {1'b1, {W{1'b0}}};
    endcase
  endfunction

  assign lu_out    = lu_fn(lu_f1, lu_f0, lu_a, lu_b);
  assign c3_lu_out = lu_fn(c3_lu_f1, c3_lu_f0, c3_lu_a, c3_lu_b);

  logic_unit_sequencer #(.WIDTH(W), .SETTLE(1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .lu_f1(lu_f1), .lu_f0(lu_f0), .lu_a(lu_a), .lu_b(lu_b), .lu_out(lu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .op_count(op_count)
  );

  logic_unit_sequencer #(.WIDTH(W), .SETTLE(3), .CNT_W(4)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(c3_cmd_valid), .cmd_ready(c3_cmd_ready), .cmd_op(c3_cmd_op),
    .cmd_a(c3_cmd_a), .cmd_b(c3_cmd_b),
    .lu_f1(c3_lu_f1), .lu_f0(c3_lu_f0), .lu_a(c3_lu_a), .lu_b(c3_lu_b), .lu_out(c3_lu_out),
    .rsp_valid(c3_rsp_valid), .rsp_ready(c3_rsp_ready), .rsp_data(c3_rsp_data),
    .rsp_err(c3_rsp_err), .op_count(c3_op_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: pop and compare whenever a response handshake is about to occur.
  always @(negedge clk) begin
    logic [W:0] e;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (q1.size() == 0) check("dut1_unexpected_rsp", 64'd1, 64'd0);
      else begin
        e = q1.pop_front();
        check("dut1_rsp", {31'd0, rsp_err, rsp_data}, {31'd0, e});
      end
    end
    if (rst_n && c3_rsp_valid && c3_rsp_ready) begin
      if (q3.size() == 0) check("dut3_unexpected_rsp", 64'd1, 64'd0);
      else begin
        e = q3.pop_front();
        check("dut3_rsp", {31'd0, c3_rsp_err, c3_rsp_data}, {31'd0, e});
      end
    end
    if (watch_f && (lu_f1 || lu_f0)) f_seen = 1'b1;
  end

  // Drive one request into the SETTLE=1 instance and measure response latency.
  task automatic issue1(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int exp_lat, input logic [W:0] exp_rsp);
    int n;
    int lat;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    q1.push_back(exp_rsp);
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin n++; @(negedge clk); end
    if (!cmd_ready) check("dut1_accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 20);
    check("dut1_latency", lat, exp_lat);
  endtask

  // Same for the SETTLE=3 instance, also checking the drives are held.
  task automatic issue3(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int exp_lat, input logic [W:0] exp_rsp);
    int n;
    int lat;
    @(posedge clk); #1;
    c3_cmd_valid = 1'b1; c3_cmd_op = op; c3_cmd_a = a; c3_cmd_b = b;
    q3.push_back(exp_rsp);
    n = 0;
    @(negedge clk);
    while (!c3_cmd_ready && n < 20) begin n++; @(negedge clk); end
    if (!c3_cmd_ready) check("dut3_accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    c3_cmd_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk); lat++;
      if (!c3_rsp_valid) begin
        check("dut3_hold_f", {62'd0, c3_lu_f1, c3_lu_f0}, {62'd0, op});
        check("dut3_hold_a", c3_lu_a, a);
        check("dut3_hold_b", c3_lu_b, b);
      end
    end while (!c3_rsp_valid && lat < 20);
    check("dut3_latency", lat, exp_lat);
    check("dut3_f_parked", {62'd0, c3_lu_f1, c3_lu_f0}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]   rop;
    logic [W-1:0] ra, rb;
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
    c3_cmd_valid = 1'b0; c3_cmd_op = 2'b00; c3_cmd_a = '0; c3_cmd_b = '0; c3_rsp_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_lu_f", {lu_f1, lu_f0}, 0);
    check("rst_lu_ab", {lu_a, lu_b}, 0);
    check("rst_op_count", op_count, 0);
    check("rst3_cmd_ready", c3_cmd_ready, 1);
    check("rst3_op_count", c3_op_count, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    c3_rsp_ready = 1'b1;

    // Back-to-back AND / OR / XOR
    issue1(2'b01, A0, B0, 2, {1'b0, 32'h40244050});
    issue1(2'b10, A0, B0, 2, {1'b0, 32'hDD75FCD7});
    issue1(2'b11, A0, B0, 2, {1'b0, 32'h9D51BC87});
    @(negedge clk);
    check("count_after_3", op_count, 3);

    // Illegal op: immediate error response, unit never selected
    watch_f = 1'b1;
    issue1(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, {1'b1, 32'h0});
    @(negedge clk);
    watch_f = 1'b0;
    check("illegal_f_idle", f_seen, 0);
    check("illegal_count", op_count, 3);
    check("illegal_back_idle", cmd_ready, 1);

    // XOR with response stalled for 5 cycles; a request pulse must be ignored
    rsp_ready = 1'b0;
    issue1(2'b11, A0, B0, 2, {1'b0, 32'h9D51BC87});
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", rsp_valid, 1);
      check("stall_data", rsp_data, 32'h9D51BC87);
      check("stall_cmd_ready", cmd_ready, 0);
      @(posedge clk); #1;
      cmd_valid = (i == 1); cmd_op = 2'b01; cmd_a = 32'h12345678; cmd_b = 32'h0F0F0F0F;
      @(negedge clk);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("release_idle", cmd_ready, 1);
    check("release_valid", rsp_valid, 0);
    check("release_count", op_count, 4);
    check("stall_pulse_ignored", lu_a, A0);

    // Reset pulse while an op is in ISSUE: abandoned, no response
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_a = A0; cmd_b = B0;
    @(negedge clk);
    check("rstissue_ready", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("rstissue_in_issue", {lu_f1, lu_f0}, 2'b10);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rstissue_valid", rsp_valid, 0);
    check("rstissue_idle", cmd_ready, 1);
    check("rstissue_f", {lu_f1, lu_f0}, 0);
    check("rstissue_count", op_count, 0);
    repeat (4) @(negedge clk);
    check("rstissue_no_rsp", rsp_valid, 0);

    // SETTLE=3: AND held for 3 cycles, response 4 cycles after accept
    issue3(2'b01, A0, B0, 4, {1'b0, 32'h40244050});
    @(negedge clk);
    check("s3_count_1", c3_op_count, 1);
    for (int i = 0; i < 14; i++) begin
      rop = 2'($urandom_range(1, 3));
      ra  = $urandom;
      rb  = $urandom;
      issue3(rop, ra, rb, 4, rsp_model(rop, ra, rb));
    end
    @(negedge clk);
    check("s3_count_max", c3_op_count, 15);
    issue3(2'b00, A0, B0, 1, rsp_model(2'b00, A0, B0));
    @(negedge clk);
    check("s3_count_err_hold", c3_op_count, 15);
    issue3(2'b10, A0, B0, 4, {1'b0, 32'hDD75FCD7});
    @(negedge clk);
    check("s3_count_wrap", c3_op_count, 0);

    repeat (3) @(negedge clk);
    check("sb1_drained", q1.size(), 0);
    check("sb3_drained", q3.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
